// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } pc_state_e;

    // Bit positions inside pc_stall_flush
    localparam int PSF_STALL = 0;
    localparam int PSF_FLUSH = 1;

    // Default sequential PC step (one 32-bit instruction)
    localparam int INSTR_BYTES_DEF = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: trap beats branch, target word-aligned.
module pc_redirect_arb #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  br_valid,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_target,
    output logic                  redir_valid,
    output logic [ADDR_WIDTH-1:0] redir_target
);

    logic [ADDR_WIDTH-1:0] sel_target;

    // Priority mux, then clear the two low bits so the PC stays aligned
    always_comb begin
        sel_target   = trap_valid ? trap_target : br_target;
        redir_valid  = trap_valid | br_valid;
        redir_target = {sel_target[ADDR_WIDTH-1:2], 2'b00};
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register sequencer and fetch-port controller.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
    parameter int                    INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] pc_cur,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic [1:0]            pc_stall_flush,
    output logic                  if_req,
    output logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_ack,
    output logic                  if_valid,
    input  logic                  id_stall,
    input  logic                  br_valid,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_target
);

    pc_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] pend_target, pend_target_nxt;
    logic                  redir_valid;
    logic [ADDR_WIDTH-1:0] redir_target;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  stall, flush;

    pc_redirect_arb #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
        .br_valid     (br_valid),
        .br_target    (br_target),
        .trap_valid   (trap_valid),
        .trap_target  (trap_target),
        .redir_valid  (redir_valid),
        .redir_target (redir_target)
    );

    // Sequential step wraps naturally at 2^ADDR_WIDTH
    assign pc_inc  = pc_cur + ADDR_WIDTH'(INSTR_BYTES);
    assign if_addr = pc_cur;
    assign if_req  = (state == FETCH) || (state == DRAIN);

    assign pc_stall_flush[PSF_STALL] = stall;
    assign pc_stall_flush[PSF_FLUSH] = flush;

    // State and parked-redirect registers; the pending flag is implied by DRAIN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    // Next-state and output decode; a redirect is only applied when no fetch is outstanding
    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        pc_next         = pc_cur;
        stall           = 1'b1;
        flush           = 1'b0;
        if_valid        = 1'b0;
        case (state)
            IDLE: begin
                pc_next   = RESET_PC;
                state_nxt = FETCH;
                if (redir_valid) begin
                    pc_next = redir_target;
                    stall   = 1'b0;
                    flush   = 1'b1;
                end
            end
            FETCH: begin
                if (if_ack) begin
                    if (redir_valid) begin
                        pc_next = redir_target;
                        stall   = 1'b0;
                        flush   = 1'b1;
                    end else begin
                        if_valid = 1'b1;
                        if (!id_stall) begin
                            pc_next = pc_inc;
                            stall   = 1'b0;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end else if (redir_valid) begin
                    // Request already on the bus: park the redirect until it retires
                    pend_target_nxt = redir_target;
                    state_nxt       = DRAIN;
                end
            end
            HOLD: begin
                if (redir_valid) begin
                    pc_next   = redir_target;
                    stall     = 1'b0;
                    flush     = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    if_valid = 1'b1;
                    if (!id_stall) begin
                        pc_next   = pc_inc;
                        stall     = 1'b0;
                        state_nxt = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (if_ack) begin
                    pc_next   = redir_valid ? redir_target : pend_target;
                    stall     = 1'b0;
                    flush     = 1'b1;
                    state_nxt = FETCH;
                end else if (redir_valid) begin
                    pend_target_nxt = redir_target;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl against a cycle-level reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_cur = RST_PC;
    logic [31:0] pc_next;
    logic [1:0]  pc_stall_flush;
    logic        if_req, if_valid;
    logic [31:0] if_addr;
    logic        if_ack = 1'b0, id_stall = 1'b0;
    logic        br_valid = 1'b0, trap_valid = 1'b0;
    logic [31:0] br_target = '0, trap_target = '0;

    pc_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .pc_stall_flush (pc_stall_flush),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ack         (if_ack),
        .if_valid       (if_valid),
        .id_stall       (id_stall),
        .br_valid       (br_valid),
        .br_target      (br_target),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an abstract view of the fetch pipeline
    bit          m_started, m_hold, m_pend;
    logic [31:0] m_ptgt, m_pc;
    bit          x_started, x_hold, x_pend;
    logic [31:0] x_ptgt;
    logic        e_req, e_valid;
    logic [1:0]  e_psf;
    logic [31:0] e_next;

    logic [67:0] got, exp;

    task automatic model_reset();
        m_started = 0; m_hold = 0; m_pend = 0; m_ptgt = '0; m_pc = RST_PC;
        pc_cur = RST_PC;
    endtask

    // Evaluate what the outputs must be this cycle and what the model becomes
    task automatic model_eval();
        bit          r;
        logic [31:0] t;
        r = trap_valid | br_valid;
        t = trap_valid ? trap_target : br_target;
        t = t & 32'hFFFF_FFFC;
        x_started = 1; x_hold = m_hold; x_pend = m_pend; x_ptgt = m_ptgt;
        e_valid = 0; e_next = m_pc; e_psf = 2'b01;
        if (!m_started) begin
            e_req  = 0;
            e_next = r ? t : RST_PC;
            e_psf  = r ? 2'b10 : 2'b01;
        end else if (m_pend) begin
            e_req = 1;
            if (if_ack) begin
                e_next = r ? t : m_ptgt; e_psf = 2'b10; x_pend = 0;
            end else if (r) x_ptgt = t;
        end else if (m_hold) begin
            e_req = 0;
            if (r) begin
                e_next = t; e_psf = 2'b10; x_hold = 0;
            end else begin
                e_valid = 1;
                if (!id_stall) begin e_next = m_pc + 4; e_psf = 2'b00; x_hold = 0; end
            end
        end else begin
            e_req = 1;
            if (if_ack) begin
                if (r) begin e_next = t; e_psf = 2'b10; end
                else begin
                    e_valid = 1;
                    if (!id_stall) begin e_next = m_pc + 4; e_psf = 2'b00; end
                    else x_hold = 1;
                end
            end else if (r) begin
                x_pend = 1; x_ptgt = t;
            end
        end
        exp = {e_req, e_valid, e_psf, e_next, m_pc};
        got = {if_req, if_valid, pc_stall_flush, pc_next, if_addr};
    endtask

    // Drive inputs (called at posedge+1), then evaluate the model at negedge
    task automatic apply(input bit ack, input bit ids, input bit bv, input logic [31:0] bt,
                         input bit tv, input logic [31:0] tt);
        if_ack = ack; id_stall = ids; br_valid = bv; br_target = bt;
        trap_valid = tv; trap_target = tt;
        @(negedge clk);
        model_eval();
    endtask

    // Clock edge: commit the model and the bench-side PC register
    task automatic tick();
        @(posedge clk);
        m_started = x_started; m_hold = x_hold; m_pend = x_pend; m_ptgt = x_ptgt;
        if (!e_psf[0]) m_pc = e_next;
        #1;
        pc_cur = m_pc;
    endtask

    task automatic test_reset();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({if_req, if_valid, pc_stall_flush, pc_next} !== {1'b0, 1'b0, 2'b01, RST_PC}) begin
            n_err++;
            $display("FAIL reset got %h exp %h", {if_req, if_valid, pc_stall_flush, pc_next},
                     {1'b0, 1'b0, 2'b01, RST_PC});
        end
        reset_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] want [3];
        want[0] = 32'h8000_0000; want[1] = 32'h8000_0004; want[2] = 32'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, '0, 0, '0);
            n_vec++;
            if (got !== exp || (i < 3 && pc_next !== want[i]) || (i > 0 && if_valid !== 1'b1)) begin
                n_err++;
                $display("FAIL seq[%0d] got %h exp %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        // PC is now 8000_0010; ack under id_stall, stay stalled, then release
        for (int i = 0; i < 4; i++) begin
            apply(i == 0, i < 3, 0, '0, 0, '0);
            n_vec++;
            if (got !== exp || (i == 3 && pc_next !== 32'h8000_0014)) begin
                n_err++;
                $display("FAIL hold[%0d] got %h exp %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            apply(i == 2, 0, i == 0, 32'h8000_0100, 0, '0);
            n_vec++;
            if (got !== exp || (i == 2 && {pc_stall_flush, if_valid, pc_next} !== {2'b10, 1'b0, 32'h8000_0100})
                || (i == 3 && if_addr !== 32'h8000_0100)) begin
                n_err++;
                $display("FAIL drain[%0d] got %h exp %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, i == 0, 32'h8000_0300, i == 0, 32'h8000_0200);
            n_vec++;
            if (got !== exp || (i == 0 && {pc_stall_flush, pc_next} !== {2'b10, 32'h8000_0200})
                || (i == 1 && pc_stall_flush[1] !== 1'b0)) begin
                n_err++;
                $display("FAIL prio[%0d] got %h exp %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_wrap_align();
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, i != 1, (i == 0) ? 32'hFFFF_FFFC : 32'h8000_0103, 0, '0);
            n_vec++;
            if (got !== exp || (i == 1 && pc_next !== 32'h0000_0000)
                || (i == 2 && pc_next !== 32'h8000_0100)) begin
                n_err++;
                $display("FAIL wrap[%0d] got %h exp %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), $urandom,
                  ($urandom_range(0, 9) == 0), $urandom);
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rand[%0d] got %h exp %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        // Park a redirect, then yank reset while the fetch is still outstanding
        apply(0, 0, 1, 32'h8000_0400, 0, '0);
        tick();
        apply(0, 0, 0, '0, 0, '0);
        n_vec++;
        if (got !== exp || if_req !== 1'b1) begin
            n_err++;
            $display("FAIL pre_rst got %h exp %h", got, exp);
        end
        @(posedge clk);
        #3;
        reset_n = 0;
        model_reset();
        #1;
        n_vec++;
        if ({if_req, if_valid, pc_stall_flush, pc_next} !== {1'b0, 1'b0, 2'b01, RST_PC}) begin
            n_err++;
            $display("FAIL rst_mid got %h exp %h", {if_req, if_valid, pc_stall_flush, pc_next},
                     {1'b0, 1'b0, 2'b01, RST_PC});
        end
        @(posedge clk);
        #1;
        reset_n = 1;
        // Stale ack right after reset must be ignored; the parked redirect is gone
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, '0, 0, '0);
            n_vec++;
            if (got !== exp || (i == 0 && {pc_stall_flush, pc_next} !== {2'b01, RST_PC})
                || (i == 1 && pc_next !== 32'h8000_0004)) begin
                n_err++;
                $display("FAIL post_rst[%0d] got %h exp %h", i, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_hold();
        test_drain();
        test_priority();
        test_wrap_align();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencer for the PC register and the instruction-fetch port of the RISC-V pipeline.
- Drives the PC register's next value and its 2-bit stall/flush control.
- Issues fetch requests at the current PC and hands fetched instructions to IF/ID.
- Arbitrates redirects: trap beats branch, branch beats sequential.
- Parks a redirect that arrives while a fetch is in flight, then applies it once that fetch retires.

Parameters:
ADDR_WIDTH, 32, PC/address width
RESET_PC, 32'h8000_0000, PC value presented while in IDLE after reset
INSTR_BYTES, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
pc_cur  in  ADDR_WIDTH  current PC, from the PC register output
pc_next  out  ADDR_WIDTH  next PC, to the PC register input
pc_stall_flush  out  2  bit0 = stall PC (hold), bit1 = flush IF/ID
if_req  out  1  fetch request, bus handshake
if_addr  out  ADDR_WIDTH  fetch address; always equals pc_cur
if_ack  in  1  fetch complete; may assert in the same cycle as if_req
if_valid  out  1  fetched instruction valid toward IF/ID
id_stall  in  1  IF/ID cannot accept this cycle
br_valid  in  1  branch/jump redirect request from EX
br_target  in  ADDR_WIDTH  branch target
trap_valid  in  1  trap/exception redirect request
trap_target  in  ADDR_WIDTH  trap vector

Behaviour:
- States: IDLE, FETCH, HOLD, DRAIN.
- Output decode: if_req = (state is FETCH or DRAIN). The PC register loads pc_next on any edge where pc_stall_flush[0]=0.
- Async reset (also mid-transaction):
  - state=IDLE, pending cleared.
  - if_req=0, if_valid=0, pc_stall_flush=2'b01, pc_next=RESET_PC.
- IDLE: stall=1, pc_next=RESET_PC. Go to FETCH on the next cycle. An if_ack seen in IDLE is ignored.
- Redirect selection: trap_valid has priority over br_valid. The selected target has bits [1:0] forced to 0.
- Default outputs: stall=1, flush=0, if_valid=0, pc_next=pc_cur.
- FETCH, no redirect:
  - No if_ack: hold.
  - if_ack with id_stall=0: if_valid=1, pc_next=pc_cur+INSTR_BYTES (modulo 2^ADDR_WIDTH, wraps to 0), stall=0, stay in FETCH. Back-to-back zero-wait fetches give 1 instruction per cycle.
  - if_ack with id_stall=1: if_valid=1, stall=1, go to HOLD.
- HOLD:
  - if_valid=1, if_req=0.
  - When id_stall=0: pc_next=pc_cur+INSTR_BYTES, stall=0, go to FETCH.
- Redirect in IDLE, HOLD, or FETCH with if_ack=1 (applied the same cycle):
  - pc_next=target, stall=0, flush=1, if_valid=0; go to FETCH.
  - The acked or held instruction is discarded.
- Redirect in FETCH with if_ack=0:
  - Latch target into pend_target, set pend=1, stall=1; go to DRAIN.
  - The in-flight request is never abandoned; if_req stays high.
- DRAIN:
  - if_req=1, if_valid=0, stall=1.
  - A new redirect in DRAIN overwrites pend_target; trap beats branch within the same cycle.
  - On if_ack: the acked data is discarded; pc_next = the redirect valid this cycle if any, else pend_target; stall=0, flush=1, pend cleared; go to FETCH.
- Flush asserts for exactly one cycle per applied redirect, and never while stall=1.
- Latency: a redirect reaches if_addr one cycle after it is applied.

Decomposition:
- Package pc_ctrl_pkg:
  - state enum {IDLE, FETCH, HOLD, DRAIN}
  - PSF_STALL=0, PSF_FLUSH=1 bit indices
  - INSTR_BYTES default
- Sub-module pc_redirect_arb: combinational trap>branch priority mux plus [1:0] alignment mask. Outputs redir_valid and redir_target.

Test Plan:
- Reset release, if_ack tied 1, id_stall=0 -> pc_next: 8000_0000 (IDLE), then 8000_0004, 8000_0008 on successive cycles; if_valid=1 every FETCH cycle.
- Ack with id_stall=1 for 3 cycles at pc 8000_0010 -> HOLD: if_valid held for 3 cycles, stall=1, pc unchanged; then pc_next=8000_0014.
- br_valid with target 8000_0100 while FETCH has no ack; ack 2 cycles later -> DRAIN, stall=1; on the ack cycle flush=1, if_valid=0, pc_next=8000_0100; next cycle if_addr=8000_0100.
- trap_valid (target 8000_0200) and br_valid (target 8000_0300) in the same cycle as ack -> pc_next=8000_0200, flush=1 for one cycle.
- pc_cur=FFFF_FFFC with ack -> pc_next=0000_0000. br_target=8000_0103 -> pc_next=8000_0100.
- reset_n low during DRAIN -> if_req=0 immediately, pend cleared, pc_stall_flush=01, pc_next=RESET_PC; a stale if_ack after reset is ignored.
